svm_dot_engine: RTL and testbench
=================================

# svm_dot_engine

Initiator-side companion of the SVM coefficient storage: owns the storage's address/read/write port. Loads a coefficient vector from an upstream stream, then on command reads coefficients back in address order and multiply-accumulates them against an incoming feature stream. Produces one signed dot product per run for the SVM decision stage.

## Interface
- DEPTH, 121: coefficients per vector, storage addresses 0..DEPTH-1
- DW, 9: signed coefficient/feature width
- AW, 8: storage address width
- ACCW, 25: signed accumulator/result width (2*DW + ceil(log2(DEPTH)))

Ports. Clock is `clk`, single domain. Reset is `rst`, synchronous, active-high.
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- load_valid  in  1  coefficient beat valid
- load_data  in  DW  signed coefficient
- load_ready  out  1  coefficient beat accepted when high with load_valid
- start  in  1  one-cycle run request; honoured only in IDLE
- feat_valid  in  1  feature beat valid
- feat_data  in  DW  signed feature
- feat_ready  out  1  feature beat accepted when high with feat_valid
- busy  out  1  high in RUN and DONE
- result_valid  out  1  one-cycle pulse, result is final
- result  out  ACCW  signed dot product; held until next start
- mem_addr  out  AW  storage address
- mem_read  out  1  storage read enable
- mem_write  out  1  storage write enable
- mem_wdata  out  DW  storage write data
- mem_rdata  in  DW  storage read data; combinational from mem_addr, 0 when mem_read low

## Operation
- States: IDLE, RUN, DONE. Reset -> IDLE; load_ptr=0, idx=0, acc=0. After reset all outputs are 0 except load_ready=1.
- IDLE: load_ready = !start. A beat is accepted when load_valid && load_ready: mem_write=1, mem_addr=load_ptr, mem_wdata=load_data. load_ptr increments and wraps DEPTH-1 -> 0. mem_read=0, feat_ready=0.
- start in IDLE -> RUN next cycle: idx=0, acc=0, load_ptr=0. start && load_valid in the same cycle: start wins and the beat is not accepted. start outside IDLE is ignored.
- RUN: mem_read=1, mem_addr=idx, feat_ready=1, mem_write=0. On a feat beat: acc += mem_rdata * feat_data, computed signed at full precision and sign-extended to ACCW; idx increments. The beat at idx==DEPTH-1 -> DONE.
- DONE: result_valid=1 for one cycle, result=acc; then IDLE.
- No overflow is possible within DEPTH terms at ACCW=25. No saturation logic.
- rst mid-LOAD or mid-RUN aborts immediately to the reset state. Storage contents are not cleared.

## Timing
- start sampled at edge 0. RUN occupies cycles 1..DEPTH with no bubbles. result_valid is high in cycle DEPTH+1. load_ready returns in cycle DEPTH+2.
- feat_valid gaps stall idx and acc. Latency grows one cycle per bubble.
- Storage read is asynchronous, so the coefficient and feature pair in the same cycle. acc updates at the accepting edge.
- Load throughput: one coefficient per cycle. The write commits at the accepting edge.
- result changes only at the end of a run. It reads 0 after reset.

## Structure
- Shared package svm_pkg: DEPTH, DW, AW, ACCW, and the state encoding IDLE=2'd0, RUN=2'd1, DONE=2'd2.
- Sub-module svm_mac: signed DW x DW multiply plus ACCW accumulator, with clear and enable inputs.
- FSM, pointers and handshake logic stay in svm_dot_engine.
- The bench instantiates the real storage block on the mem_* port.

## Test plan
- Load 121 beats of +1, start, 121 feature beats of +1 with no bubbles -> result=121, result_valid exactly in cycle 122 after start.
- Coefficients all -256, features all -256 -> result=7929856. Coefficients all +255, features all -256 -> result=-7898880. No wrap.
- Coefficient[i]=i-60, feature=+1 at i=120 and 0 elsewhere, with a feat_valid gap every 3rd cycle -> result=60. result_valid is delayed by exactly the number of bubbles.
- Load 122 beats of value k (k=0..121) -> storage address 0 holds 121 (pointer wrap). The run then reads 121 at idx 0.
- start asserted together with load_valid in IDLE -> beat not written, load_ready=0 that cycle. Extra start pulses during RUN have no effect.
- rst asserted at idx=50 -> next cycle IDLE, busy=0, result=0, no result_valid pulse. A new full run then gives the correct result.

Source files
------------

// File: rtl/svm_pkg.sv
// Shared sizing and FSM encoding for the SVM dot-product engine.
package svm_pkg;
  localparam int DEPTH = 121;
  localparam int DW    = 9;
  localparam int AW    = 8;
  localparam int ACCW  = 25;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/svm_mac.sv
// Signed DW x DW multiply feeding an ACCW accumulator with clear and enable.
module svm_mac
  import svm_pkg::*;
(
  input  logic            clk,
  input  logic            i_clr,
  input  logic            i_en,
  input  logic [DW-1:0]   i_a,
  input  logic [DW-1:0]   i_b,
  output logic [ACCW-1:0] o_acc_next
);
  logic signed [2*DW-1:0] w_prod;
  logic signed [ACCW-1:0] w_prod_ext;
  logic signed [ACCW-1:0] w_sum;
  logic signed [ACCW-1:0] r_acc;

  assign w_prod     = $signed(i_a) * $signed(i_b);
  assign w_prod_ext = {{(ACCW-2*DW){w_prod[2*DW-1]}}, w_prod};
  assign w_sum      = r_acc + w_prod_ext;
  // Exposes the post-beat sum so the owner can latch the final term without a bubble.
  assign o_acc_next = w_sum;

  always_ff @(posedge clk) begin
    if (i_clr) begin
      r_acc <= '0;
    end else if (i_en) begin
      r_acc <= w_sum;
    end
  end
endmodule

// File: rtl/svm_dot_engine.sv
// Loads a coefficient vector into storage, then streams features against it
// and reports one signed dot product per run.
module svm_dot_engine
  import svm_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            load_valid,
  input  logic [DW-1:0]   load_data,
  output logic            load_ready,
  input  logic            start,
  input  logic            feat_valid,
  input  logic [DW-1:0]   feat_data,
  output logic            feat_ready,
  output logic            busy,
  output logic            result_valid,
  output logic [ACCW-1:0] result,
  output logic [AW-1:0]   mem_addr,
  output logic            mem_read,
  output logic            mem_write,
  output logic [DW-1:0]   mem_wdata,
  input  logic [DW-1:0]   mem_rdata
);
  state_t          r_state;
  logic [AW-1:0]   r_load_ptr;
  logic [AW-1:0]   r_idx;
  logic [ACCW-1:0] r_result;

  logic            w_idle;
  logic            w_run;
  logic            w_start;
  logic            w_load_fire;
  logic            w_feat_fire;
  logic [ACCW-1:0] w_acc_next;

  assign w_idle      = (r_state == IDLE);
  assign w_run       = (r_state == RUN);
  assign w_start     = w_idle && start;
  assign w_load_fire = w_idle && load_valid && !start;
  assign w_feat_fire = w_run && feat_valid;

  svm_mac u_mac (
    .clk        (clk),
    .i_clr      (rst || w_start),
    .i_en       (w_feat_fire),
    .i_a        (mem_rdata),
    .i_b        (feat_data),
    .o_acc_next (w_acc_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_load_ptr <= '0;
      r_idx      <= '0;
      r_result   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_state    <= RUN;
            r_idx      <= '0;
            r_load_ptr <= '0;
          end else if (load_valid) begin
            r_load_ptr <= (r_load_ptr == AW'(DEPTH-1)) ? '0 : r_load_ptr + 1'b1;
          end
        end
        RUN: begin
          if (feat_valid) begin
            if (r_idx == AW'(DEPTH-1)) begin
              r_state  <= DONE;
              r_result <= w_acc_next;
              r_idx    <= '0;
            end else begin
              r_idx <= r_idx + 1'b1;
            end
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign load_ready   = w_idle && !start;
  assign feat_ready   = w_run;
  assign busy         = !w_idle;
  assign result_valid = (r_state == DONE);
  assign result       = r_result;
  assign mem_addr     = w_run ? r_idx : r_load_ptr;
  assign mem_read     = w_run;
  assign mem_write    = w_load_fire;
  assign mem_wdata    = w_load_fire ? load_data : '0;
endmodule

// File: tb/tb_svm_dot_engine.sv
// Directed bench for svm_dot_engine with a behavioural asynchronous-read storage.
module tb_svm_dot_engine;
  logic               clk = 1'b0;
  logic               rst;
  logic               load_valid;
  logic [8:0]         load_data;
  logic               load_ready;
  logic               start;
  logic               feat_valid;
  logic [8:0]         feat_data;
  logic               feat_ready;
  logic               busy;
  logic               result_valid;
  logic signed [24:0] result;
  logic [7:0]         mem_addr;
  logic               mem_read;
  logic               mem_write;
  logic [8:0]         mem_wdata;
  logic [8:0]         mem_rdata;

  logic [8:0] store [0:255];
  logic signed [8:0] coef [0:121];
  logic signed [8:0] feat [0:120];

  int n_assert = 0;
  int n_fail   = 0;
  int lat;
  logic signed [24:0] res;
  logic [8:0] saved0;

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_write) store[mem_addr] <= mem_wdata;
  assign mem_rdata = mem_read ? store[mem_addr] : 9'd0;

  svm_dot_engine dut (
    .clk(clk), .rst(rst),
    .load_valid(load_valid), .load_data(load_data), .load_ready(load_ready),
    .start(start), .feat_valid(feat_valid), .feat_data(feat_data), .feat_ready(feat_ready),
    .busy(busy), .result_valid(result_valid), .result(result),
    .mem_addr(mem_addr), .mem_read(mem_read), .mem_write(mem_write),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic load_vec(input int n);
    for (int i = 0; i < n; i++) begin
      load_valid = 1'b1;
      load_data  = coef[i];
      @(posedge clk); #1;
    end
    load_valid = 1'b0;
    load_data  = '0;
  endtask

  task automatic do_run(input int gap_mod, input bit extra_start,
                        output int lat_o, output logic signed [24:0] res_o);
    int idx_f;
    int c;
    bit seen;
    idx_f = 0; seen = 0; lat_o = -1; res_o = '0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    c = 1;
    while (!seen && c < 600) begin
      feat_valid = (idx_f < 121) && !(gap_mod != 0 && (c % gap_mod) == 0);
      feat_data  = feat_valid ? feat[idx_f] : '0;
      start      = extra_start && (c == 10);
      @(negedge clk);
      if (result_valid) begin
        seen = 1; lat_o = c; res_o = result;
      end else if (feat_valid && feat_ready) begin
        idx_f++;
      end
      @(posedge clk); #1;
      c++;
    end
    feat_valid = 1'b0;
    feat_data  = '0;
    start      = 1'b0;
  endtask

  task automatic fill(input int mode);
    for (int i = 0; i < 122; i++) begin
      case (mode)
        0: coef[i] = 9'sd1;
        1: coef[i] = -9'sd256;
        2: coef[i] = 9'sd255;
        3: coef[i] = 9'(i - 60);
        default: coef[i] = 9'(i);
      endcase
    end
  endtask

  task automatic fill_feat(input int mode);
    for (int i = 0; i < 121; i++) begin
      case (mode)
        0: feat[i] = 9'sd1;
        1: feat[i] = -9'sd256;
        2: feat[i] = (i == 120) ? 9'sd1 : 9'sd0;
        default: feat[i] = (i == 0) ? 9'sd1 : 9'sd0;
      endcase
    end
  endtask

  initial begin
    rst = 1'b1; load_valid = 0; load_data = '0; start = 0; feat_valid = 0; feat_data = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_load_ready", 32'(load_ready), 1);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_result_valid", 32'(result_valid), 0);
    chk("reset_result", result, 0);
    chk("reset_feat_ready", 32'(feat_ready), 0);
    chk("reset_mem_rw", {30'd0, mem_read, mem_write}, 0);
    chk("reset_mem_addr", 32'(mem_addr), 0);
    @(posedge clk); #1;

    // Step 1: all ones.
    fill(0); fill_feat(0); load_vec(121);
    do_run(0, 0, lat, res);
    chk("ones_result", res, 121);
    chk("ones_latency", lat, 122);
    @(negedge clk);
    chk("ones_pulse_one_cycle", 32'(result_valid), 0);
    chk("ones_load_ready_back", 32'(load_ready), 1);
    chk("ones_result_held", result, 121);
    @(posedge clk); #1;

    // Step 2: extreme negative magnitudes.
    fill(1); fill_feat(1); load_vec(121);
    do_run(0, 0, lat, res);
    chk("neg_neg_result", res, 7929856);

    // Step 3: +255 against -256.
    fill(2); load_vec(121);
    do_run(0, 0, lat, res);
    chk("pos_neg_result", res, -7898880);

    // Step 4: ramp coefficients with a bubble every 3rd cycle; 60 bubbles.
    fill(3); fill_feat(2); load_vec(121);
    do_run(3, 0, lat, res);
    chk("gap_result", res, 60);
    chk("gap_latency", lat, 182);

    // Step 5: 122 beats wrap the load pointer back to address 0.
    fill(4); load_vec(122);
    chk("wrap_store0", 32'(store[0]), 121);
    chk("wrap_store1", 32'(store[1]), 1);
    fill_feat(3);
    do_run(0, 0, lat, res);
    chk("wrap_run_idx0", res, 121);

    // Step 6: start collides with a load beat; extra start inside RUN.
    saved0 = store[0];
    fill_feat(0);
    load_valid = 1'b1; load_data = 9'd77; start = 1'b1;
    @(negedge clk);
    chk("collide_load_ready", 32'(load_ready), 0);
    chk("collide_mem_write", 32'(mem_write), 0);
    @(posedge clk); #1;
    load_valid = 1'b0; start = 1'b0; load_data = '0;
    chk("collide_store_kept", 32'(store[0]), 32'(saved0));
    chk("collide_busy", 32'(busy), 1);
    // Already in RUN: repeat via do_run after returning to IDLE is not needed,
    // so drain this run manually with features of +1.
    begin
      int c2 = 1; bit seen2 = 0; int fed = 0;
      lat = -1;
      while (!seen2 && c2 < 400) begin
        feat_valid = (fed < 121);
        feat_data  = 9'sd1;
        start      = (c2 == 10) || (c2 == 40);
        @(negedge clk);
        if (result_valid) begin seen2 = 1; lat = c2; res = result; end
        else if (feat_valid && feat_ready) fed++;
        @(posedge clk); #1;
        c2++;
      end
      feat_valid = 0; start = 0;
    end
    chk("extra_start_result", res, 7381);
    chk("extra_start_latency", lat, 122);

    // Step 7: reset at idx 50 aborts the run.
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 50; i++) begin
      feat_valid = 1'b1; feat_data = 9'sd1;
      @(posedge clk); #1;
    end
    feat_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("abort_no_pulse_before", 32'(result_valid), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_result", result, 0);
    chk("abort_result_valid", 32'(result_valid), 0);
    chk("abort_load_ready", 32'(load_ready), 1);
    @(posedge clk); #1;
    do_run(0, 0, lat, res);
    chk("after_abort_result", res, 7381);
    chk("after_abort_latency", lat, 122);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
